// File: rtl/div_result_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : div_result_bcd
//  Description : Captures a packed {remainder, quotient} divider result on
//                in_valid and converts each field to two packed-BCD digits
//                using an iterative shift-add-3 (double-dabble) sequence.
//                The quotient is converted first, then the remainder. Both
//                results are published together with a one-cycle done pulse.
//  Ports       : clk      - rising-edge clock
//                rst      - asynchronous active-high reset
//                in_valid - result valid, sampled only while idle
//                rslt     - [QW-1:0] quotient, [QW+RW-1:QW] remainder
//                busy     - high from the capture edge until done
//                done     - one-cycle pulse, BCD outputs valid from here on
//                quot_bcd - quotient {tens, ones}
//                rem_bcd  - remainder {tens, ones}
//  Revision    : 1.0 - initial release
// ============================================================================
module div_result_bcd #(
    parameter int QW = 4,
    parameter int RW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [QW+RW-1:0]  rslt,
    output logic              busy,
    output logic              done,
    output logic [7:0]        quot_bcd,
    output logic [7:0]        rem_bcd
);

    // Shift register is as wide as the wider field; each field is loaded
    // left-aligned so its MSB always leaves from the top bit.
    localparam int FW = (QW > RW) ? QW : RW;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CONV_Q = 2'd1;
    localparam logic [1:0] S_CONV_R = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [2:0] C_QLOAD = 3'(QW - 1);
    localparam logic [2:0] C_RLOAD = 3'(RW - 1);

    logic [1:0]    state_q,     state_d;
    logic [FW-1:0] field_q,     field_d;
    logic [RW-1:0] rem_field_q, rem_field_d;
    logic [7:0]    scratch_q,   scratch_d;
    logic [7:0]    hold_q,      hold_d;
    logic [2:0]    cnt_q,       cnt_d;
    logic          busy_q,      busy_d;
    logic          done_q,      done_d;
    logic [7:0]    quot_bcd_q,  quot_bcd_d;
    logic [7:0]    rem_bcd_q,   rem_bcd_d;

    logic [7:0]    w_adj;
    logic [7:0]    w_step_scratch;
    logic [FW-1:0] w_step_field;
    logic [FW-1:0] w_q_aligned;
    logic [FW-1:0] w_r_aligned;

    // One double-dabble step: correct both nibbles, then shift the field
    // MSB into the scratch LSB.
    always_comb begin
        w_adj = scratch_q;
        if (scratch_q[3:0] >= 4'd5) w_adj[3:0] = scratch_q[3:0] + 4'd3;
        if (scratch_q[7:4] >= 4'd5) w_adj[7:4] = scratch_q[7:4] + 4'd3;
        w_step_scratch = {w_adj[6:0], field_q[FW-1]};
        w_step_field   = field_q << 1;
    end

    always_comb begin
        w_q_aligned             = '0;
        w_q_aligned[FW-1 -: QW] = rslt[QW-1:0];
        w_r_aligned             = '0;
        w_r_aligned[FW-1 -: RW] = rem_field_q;
    end

    always_comb begin
        state_d     = state_q;
        field_d     = field_q;
        rem_field_d = rem_field_q;
        scratch_d   = scratch_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quot_bcd_d  = quot_bcd_q;
        rem_bcd_d   = rem_bcd_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d     = S_CONV_Q;
                    field_d     = w_q_aligned;
                    rem_field_d = rslt[QW+RW-1:QW];
                    scratch_d   = 8'h00;
                    cnt_d       = C_QLOAD;
                    busy_d      = 1'b1;
                end
            end
            S_CONV_Q: begin
                scratch_d = w_step_scratch;
                field_d   = w_step_field;
                cnt_d     = cnt_q - 3'd1;
                if (cnt_q == 3'd0) begin
                    // Final quotient step: park the result, start remainder.
                    hold_d    = w_step_scratch;
                    scratch_d = 8'h00;
                    field_d   = w_r_aligned;
                    cnt_d     = C_RLOAD;
                    state_d   = S_CONV_R;
                end
            end
            S_CONV_R: begin
                scratch_d = w_step_scratch;
                field_d   = w_step_field;
                cnt_d     = cnt_q - 3'd1;
                if (cnt_q == 3'd0) begin
                    cnt_d   = 3'd0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                quot_bcd_d = hold_q;
                rem_bcd_d  = scratch_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            field_q     <= '0;
            rem_field_q <= '0;
            scratch_q   <= 8'h00;
            hold_q      <= 8'h00;
            cnt_q       <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quot_bcd_q  <= 8'h00;
            rem_bcd_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            field_q     <= field_d;
            rem_field_q <= rem_field_d;
            scratch_q   <= scratch_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quot_bcd_q  <= quot_bcd_d;
            rem_bcd_q   <= rem_bcd_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quot_bcd = quot_bcd_q;
    assign rem_bcd  = rem_bcd_q;

endmodule
`default_nettype wire

// File: tb/tb_div_result_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_result_bcd
//  Description : Self-checking bench for div_result_bcd (QW=RW=4). Expected
//                BCD pairs are queued when a request is driven and popped
//                when done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_result_bcd;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] rslt;
    logic       busy;
    logic       done;
    logic [7:0] quot_bcd;
    logic [7:0] rem_bcd;

    int checks   = 0;
    int failures = 0;

    logic [15:0] sb[$];

    div_result_bcd #(.QW(4), .RW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .rslt     (rslt),
        .busy     (busy),
        .done     (done),
        .quot_bcd (quot_bcd),
        .rem_bcd  (rem_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int r, input int q);
        sb.push_back({to_bcd(q), to_bcd(r)});
    endtask

    // Waits (bounded) for done; returns number of cycles waited.
    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc = 0;
        busy_cyc = 0;
        while (!done && cyc < 30) begin
            if (busy) busy_cyc++;
            step();
            cyc++;
        end
    endtask

    task automatic pop_check(input string tag);
        logic [15:0] e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 16'd1, 16'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_quot"}, {8'h00, quot_bcd}, {8'h00, e[15:8]});
            check({tag, "_rem"},  {8'h00, rem_bcd},  {8'h00, e[7:0]});
        end
    endtask

    task automatic do_conv(input string tag, input int r, input int q);
        int cyc, bcyc;
        rslt     = {4'(r), 4'(q)};
        in_valid = 1'b1;
        push_exp(r, q);
        step();
        in_valid = 1'b0;
        rslt     = 8'hA5;
        wait_done(cyc, bcyc);
        check({tag, "_latency"}, 16'(cyc), 16'd9);
        check({tag, "_busy_cycles"}, 16'(bcyc), 16'd9);
        check({tag, "_busy_at_done"}, {15'd0, busy}, 16'd0);
        pop_check(tag);
        step();
        check({tag, "_done_pulse"}, {15'd0, done}, 16'd0);
    endtask

    initial begin
        int cyc, bcyc, pulses, hold_bad;
        logic [7:0] held_q, held_r;

        rst      = 1'b1;
        in_valid = 1'b0;
        rslt     = 8'h00;
        #3;
        check("reset_busy", {15'd0, busy}, 16'd0);
        check("reset_done", {15'd0, done}, 16'd0);
        check("reset_outs", {quot_bcd, rem_bcd}, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Basic conversions including boundaries.
        do_conv("r10q0", 10, 0);
        do_conv("r1q14", 1, 14);
        do_conv("r0q0", 0, 0);
        do_conv("r15q15", 15, 15);
        do_conv("r9q9", 9, 9);

        // Second request mid-conversion is dropped; rslt change ignored.
        rslt     = {4'd1, 4'd12};
        in_valid = 1'b1;
        push_exp(1, 12);
        step();
        in_valid = 1'b0;
        repeat (3) step();
        in_valid = 1'b1;
        rslt     = {4'd3, 4'd3};
        step();
        in_valid = 1'b0;
        wait_done(cyc, bcyc);
        check("midreq_latency", 16'(cyc + 4), 16'd9);
        pop_check("midreq");
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done) pulses++;
        end
        check("midreq_no_extra_done", 16'(pulses), 16'd0);
        check("midreq_outs_hold", {quot_bcd, rem_bcd}, 16'h1201);

        // in_valid held high: back-to-back captures, pulses 10 apart.
        rslt     = {4'd2, 4'd7};
        in_valid = 1'b1;
        push_exp(2, 7);
        step();
        wait_done(cyc, bcyc);
        check("held_first_latency", 16'(cyc), 16'd9);
        pop_check("held_first");
        held_q = quot_bcd;
        held_r = rem_bcd;
        rslt   = {4'd5, 4'd11};
        push_exp(5, 11);
        step();
        check("held_recapture_busy", {15'd0, busy}, 16'd1);
        in_valid = 1'b0;
        cyc      = 1;
        hold_bad = 0;
        while (!done && cyc < 30) begin
            if (quot_bcd !== held_q || rem_bcd !== held_r) hold_bad++;
            step();
            cyc++;
        end
        check("held_done_spacing", 16'(cyc), 16'd10);
        check("held_outs_hold", 16'(hold_bad), 16'd0);
        pop_check("held_second");

        // Asynchronous reset during CONV_R aborts immediately.
        step();
        rslt     = {4'd4, 4'd9};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", {15'd0, busy}, 16'd0);
        check("abort_done", {15'd0, done}, 16'd0);
        check("abort_outs", {quot_bcd, rem_bcd}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done || busy) pulses++;
        end
        check("abort_stays_idle", 16'(pulses), 16'd0);
        do_conv("after_abort", 3, 13);

        check("sb_drained", 16'(sb.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_result_bcd.md
Name: div_result_bcd

Overview:
- Sits directly downstream of the restoring divider.
- Captures the divider's packed result word {remainder, quotient} on a valid strobe.
- Converts each field to two packed-BCD digits with an iterative shift-add-3 (double-dabble) state machine.
- Presents both BCD results to the display/monitor logic with a one-cycle done pulse.

Parameters:
- QW, 4, quotient field width in bits (rslt[QW-1:0]); legal range 1..6.
- RW, 4, remainder field width in bits (rslt[QW+RW-1:QW]); legal range 1..6.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  divider result valid; sampled only in IDLE.
- rslt  input  QW+RW  divider result; [QW-1:0] = quotient, [QW+RW-1:QW] = remainder.
- busy  output  1  high from the capture edge until done is asserted.
- done  output  1  one-cycle pulse; BCD outputs are valid from this cycle on.
- quot_bcd  output  8  quotient as two BCD digits, {tens, ones}.
- rem_bcd  output  8  remainder as two BCD digits, {tens, ones}.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, quot_bcd=8'h00, rem_bcd=8'h00; all internal shift registers and counters cleared.
- States and transitions:
  - IDLE -> CONV_Q when in_valid=1 at a clock edge. At that edge: latch rslt into a field register, clear the 8-bit BCD scratch, load bit counter = QW-1, busy<=1.
  - CONV_Q: one double-dabble step per cycle: each BCD nibble >=5 gets +3, then shift {scratch, field} left 1 with the field MSB entering scratch LSB.
  - CONV_Q -> CONV_R after QW steps. At that transition: save scratch into a quotient holding register, clear scratch, load counter = RW-1.
  - CONV_R: identical step on the remainder field, RW steps.
  - CONV_R -> DONE after RW steps.
  - DONE: register quot_bcd/rem_bcd from the holding registers; done=1 for exactly this cycle; busy<=0. Next state is IDLE.
- Latency: capture edge E -> done high in the cycle following edge E+QW+RW+1 (default E+9). Default throughput is one conversion per 10 cycles.
- Arithmetic: add-3 is applied before the shift within the same cycle, on both nibbles independently. Add-3 is never applied after the final shift. Max value 63 (QW/RW=6) fits two digits, so no overflow path exists.
- Input handling:
  - rslt is sampled only on the capture edge; changes during busy have no effect.
  - in_valid is ignored in CONV_Q, CONV_R and DONE; there is no queueing.
  - in_valid held high continuously captures again on the first edge in IDLE, i.e. the cycle after done.
- Outputs quot_bcd/rem_bcd hold their last value between done pulses and update only in DONE.
- Reset asserted mid-conversion aborts immediately: outputs return to 0 and no done pulse follows. After deassertion the block waits in IDLE for a fresh in_valid.
- Undriven or X rslt at capture is not checked; the result is undefined for that conversion only.

Test Plan:
- Reset, then rslt={4'd10,4'd0}, in_valid pulse -> busy high 9 cycles, done pulse at capture+9; quot_bcd=8'h00, rem_bcd=8'h10.
- rslt={4'd1,4'd14} (127/9) -> quot_bcd=8'h14, rem_bcd=8'h01. rslt={4'd0,4'd0} -> 8'h00, 8'h00.
- Max values: rslt={4'd15,4'd15} -> quot_bcd=8'h15, rem_bcd=8'h15. rslt={4'd9,4'd9} -> 8'h09, 8'h09 (no spurious add-3 after the final shift).
- in_valid pulsed and rslt changed to {4'd3,4'd3} mid-conversion of {4'd1,4'd12} -> single done; outputs 8'h12/8'h01; second request dropped.
- in_valid held high across two results -> second capture on the edge after the done cycle; done pulses exactly 10 cycles apart; outputs hold between pulses.
- rst asserted asynchronously between edges during CONV_R -> busy, done and outputs go 0 immediately (before the next edge); no done pulse; next request converts correctly.
